// File: rtl/wrr_pkt_arb.sv
// wrr_pkt_arb: packet-aware weighted round-robin arbiter.
// Shares one downstream req/gnt port with payload among NumIn requesters.
// The owner only changes at packet boundaries (last_i). Each requester may
// send up to its programmed weight of packets per turn before the turn
// rotates to the next requester.
//
// Ports:
//   clk_i, rst_ni   clock (rising edge), async active-low reset
//   flush_i         synchronous clear of all state
//   weight_i        packets per turn, field i at [i*WeightWidth +: WeightWidth], 0 acts as 1
//   req_i, last_i   per-requester valid and end-of-packet flag
//   data_i          per-requester payload
//   gnt_o           per-requester ready
//   req_o, gnt_i    downstream valid / ready
//   data_o, idx_o   selected payload and requester index
//   busy_o          registered: a requester currently owns the port
//
// state | meaning
// IDLE  | no owner; pick the first requester from ptr_q with wrap-around
// OWN   | owner_q holds the port; between_q marks a packet boundary
//       | with credit left, where a silent owner releases in-cycle
module wrr_pkt_arb #(
   parameter int unsigned NumIn       = 4,
   parameter int unsigned DataWidth   = 32,
   parameter type         DataType    = logic [DataWidth-1:0],
   parameter int unsigned WeightWidth = 4,
   parameter int unsigned IdxWidth    = $clog2(NumIn)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic [NumIn*WeightWidth-1:0] weight_i,
   input  logic [NumIn-1:0]             req_i,
   input  logic [NumIn-1:0]             last_i,
   input  DataType                      data_i [NumIn],
   output logic [NumIn-1:0]             gnt_o,
   output logic                         req_o,
   input  logic                         gnt_i,
   output DataType                      data_o,
   output logic [IdxWidth-1:0]          idx_o,
   output logic                         busy_o
);

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

   state_e                 state_q;
   logic [IdxWidth-1:0]    owner_q;
   logic [IdxWidth-1:0]    ptr_q;
   logic [WeightWidth-1:0] credit_q;
   logic                   between_q;
   logic                   busy_q;

   logic [WeightWidth-1:0] weight_arr [NumIn];
   logic                   arb_mode;
   logic                   any_req;
   logic                   found;
   logic [IdxWidth-1:0]    start;
   logic [IdxWidth-1:0]    sel;
   logic [IdxWidth-1:0]    cur;
   logic [WeightWidth-1:0] ld_credit;
   logic                   acc;
   logic                   lst;

   function automatic logic [IdxWidth-1:0] nxt_idx(input logic [IdxWidth-1:0] i);
      return (i == IdxWidth'(NumIn - 1)) ? '0 : i + IdxWidth'(1);
   endfunction

   for (genvar g = 0; g < int'(NumIn); g++) begin : g_weight
      assign weight_arr[g] = weight_i[g*WeightWidth +: WeightWidth];
   end

   // Arbitration runs in IDLE and when a between-packets owner goes quiet;
   // in the latter case the search starts just after the releasing owner.
   always_comb begin
      arb_mode = (state_q == IDLE) || (between_q && !req_i[owner_q]);
      any_req  = |req_i;
      start    = (state_q == IDLE) ? ptr_q : nxt_idx(owner_q);
      sel      = start;
      found    = 1'b0;
      for (int k = 0; k < int'(NumIn); k++) begin
         int c;
         c = int'(start) + k;
         if (c >= int'(NumIn)) c = c - int'(NumIn);
         if (!found && req_i[c]) begin
            sel   = IdxWidth'(c);
            found = 1'b1;
         end
      end
      ld_credit = (weight_arr[sel] == '0) ? '0 : weight_arr[sel] - WeightWidth'(1);
      cur       = arb_mode ? sel : owner_q;

      req_o  = arb_mode ? any_req : req_i[owner_q];
      gnt_o  = '0;
      idx_o  = '0;
      data_o = '0;
      if (!arb_mode || any_req) begin
         idx_o      = cur;
         data_o     = data_i[cur];
         gnt_o[cur] = gnt_i;
      end
      acc = req_o && gnt_i;
      lst = last_i[cur];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         credit_q  <= '0;
         between_q <= 1'b0;
         busy_q    <= 1'b0;
      end else if (flush_i) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         credit_q  <= '0;
         between_q <= 1'b0;
         busy_q    <= 1'b0;
      end else if (arb_mode) begin
         if (any_req) begin
            owner_q  <= sel;
            credit_q <= ld_credit;
            if (acc && lst && (ld_credit == '0)) begin
               state_q   <= IDLE;
               busy_q    <= 1'b0;
               between_q <= 1'b0;
               ptr_q     <= nxt_idx(sel);
            end else begin
               // An unaccepted beat lands here with between_q=0, locking idx_o.
               state_q   <= OWN;
               busy_q    <= 1'b1;
               between_q <= acc && lst;
               if (state_q == OWN) ptr_q <= nxt_idx(owner_q);
            end
         end else if (state_q == OWN) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            between_q <= 1'b0;
            ptr_q     <= nxt_idx(owner_q);
         end
      end else if (acc) begin
         if (lst) begin
            if (credit_q == '0) begin
               state_q   <= IDLE;
               busy_q    <= 1'b0;
               between_q <= 1'b0;
               ptr_q     <= nxt_idx(owner_q);
            end else begin
               credit_q  <= credit_q - WeightWidth'(1);
               between_q <= 1'b1;
            end
         end else begin
            between_q <= 1'b0;
         end
      end
   end

   assign busy_o = busy_q;

endmodule

// File: tb/tb_wrr_pkt_arb.sv
// tb_wrr_pkt_arb: directed bench for wrr_pkt_arb (NumIn=4, 32-bit data,
// 4-bit weights). Inputs change 1 ns after the rising edge; combinational
// outputs are checked 1 ns later, registered state 1 ns after the edge.
module tb_wrr_pkt_arb;
   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic [15:0] weight_i;
   logic [3:0]  req_i;
   logic [3:0]  last_i;
   logic [31:0] data_i [4];
   logic [3:0]  gnt_o;
   logic        req_o;
   logic        gnt_i;
   logic [31:0] data_o;
   logic [1:0]  idx_o;
   logic        busy_o;

   int n_run  = 0;
   int n_fail = 0;

   wrr_pkt_arb dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .flush_i  (flush_i),
      .weight_i (weight_i),
      .req_i    (req_i),
      .last_i   (last_i),
      .data_i   (data_i),
      .gnt_o    (gnt_o),
      .req_o    (req_o),
      .gnt_i    (gnt_i),
      .data_o   (data_o),
      .idx_o    (idx_o),
      .busy_o   (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic g);
      req_i  = r;
      last_i = l;
      gnt_i  = g;
      #1;
   endtask

   // Requester obligation: an offered, unaccepted beat must be held.
   logic        prev_hold = 1'b0;
   logic [1:0]  prev_idx;
   logic [31:0] prev_data;
   logic        prev_last;
   always @(posedge clk_i) begin
      if (rst_ni && !flush_i && prev_hold)
         assert (req_i[prev_idx] && data_i[prev_idx] === prev_data && last_i[prev_idx] === prev_last)
            else $error("requester %0d did not hold its offered beat", prev_idx);
      prev_hold = rst_ni && !flush_i && req_o && !gnt_i;
      prev_idx  = idx_o;
      prev_data = data_i[idx_o];
      prev_last = last_i[idx_o];
   end

   initial begin
      for (int i = 0; i < 4; i++) data_i[i] = 32'hA0 + i;
      rst_ni   = 1'b0;
      flush_i  = 1'b0;
      weight_i = 16'h1111;
      req_i    = '0;
      last_i   = '0;
      gnt_i    = 1'b0;
      #12;
      chk("rst_busy", busy_o, 0);
      chk("rst_ptr", dut.ptr_q, 0);
      chk("rst_req_o", req_o, 0);
      chk("rst_gnt_o", gnt_o, 0);
      rst_ni = 1'b1;
      tick();

      // 1: unit weights, everyone requesting single-beat packets
      for (int k = 0; k < 5; k++) begin
         drive(4'b1111, 4'b1111, 1'b1);
         chk("t1_idx", idx_o, k % 4);
         chk("t1_gnt", gnt_o, 32'(4'b0001 << (k % 4)));
         chk("t1_data", data_o, 32'hA0 + (k % 4));
         chk("t1_busy", busy_o, 0);
         tick();
      end

      // 2: requester 2 sends a 4-beat packet, requester 0 waits
      for (int b = 1; b <= 4; b++) begin
         drive(4'b0101, {1'b0, (b == 4), 1'b0, 1'b1}, 1'b1);
         chk("t2_idx", idx_o, 2);
         chk("t2_gnt", gnt_o, 4'b0100);
         chk("t2_busy", busy_o, (b >= 2));
         tick();
      end
      drive(4'b0001, 4'b0001, 1'b1);
      chk("t2_next_idx", idx_o, 0);
      chk("t2_next_gnt", gnt_o, 4'b0001);
      chk("t2_next_busy", busy_o, 0);
      tick();
      chk("t2_ptr", dut.ptr_q, 1);

      // 3: weight 3 on requester 1, three single-beat packets, then 3
      weight_i = 16'h1131;
      for (int c = 0; c < 3; c++) begin
         drive(4'b1010, 4'b1010, 1'b1);
         chk("t3_idx", idx_o, 1);
         tick();
         chk("t3_credit", dut.credit_q, 2 - c);
         chk("t3_busy", busy_o, 1);
      end
      drive(4'b1000, 4'b1000, 1'b1);
      chk("t3_rel_idx", idx_o, 3);
      chk("t3_rel_req", req_o, 1);
      tick();
      chk("t3_rel_busy", busy_o, 0);
      drive(4'b0001, 4'b0001, 1'b1);
      chk("t3_solo_idx", idx_o, 0);
      tick();
      chk("t3_ptr", dut.ptr_q, 1);

      // 4: requester 1 sends one packet then goes quiet
      drive(4'b1010, 4'b1010, 1'b1);
      chk("t4_first_idx", idx_o, 1);
      tick();
      chk("t4_credit", dut.credit_q, 2);
      drive(4'b1000, 4'b0000, 1'b1);
      chk("t4_rel_req", req_o, 1);
      chk("t4_rel_idx", idx_o, 3);
      chk("t4_rel_gnt", gnt_o, 4'b1000);
      chk("t4_rel_data", data_o, 32'hA3);
      tick();
      chk("t4_ptr", dut.ptr_q, 2);
      chk("t4_busy", busy_o, 1);
      drive(4'b1000, 4'b1000, 1'b1);
      chk("t4_tail_idx", idx_o, 3);
      tick();
      chk("t4_end_busy", busy_o, 0);
      chk("t4_end_ptr", dut.ptr_q, 0);

      // 5: offered beat stalls while a higher-priority requester appears
      drive(4'b0001, 4'b0001, 1'b1);
      tick();
      chk("t5_ptr", dut.ptr_q, 1);
      for (int c = 0; c < 3; c++) begin
         drive(4'b0001, 4'b0001, 1'b0);
         chk("t5_stall_idx", idx_o, 0);
         chk("t5_stall_gnt", gnt_o, 0);
         tick();
      end
      drive(4'b0011, 4'b0011, 1'b0);
      chk("t5_lock_idx", idx_o, 0);
      chk("t5_lock_req", req_o, 1);
      tick();
      drive(4'b0011, 4'b0011, 1'b1);
      chk("t5_acc_idx", idx_o, 0);
      chk("t5_acc_gnt", gnt_o, 4'b0001);
      tick();
      chk("t5_acc_busy", busy_o, 0);
      drive(4'b0010, 4'b0010, 1'b1);
      chk("t5_next_idx", idx_o, 1);
      tick();

      // 6: flush mid-packet, then async reset mid-turn
      drive(4'b1000, 4'b0000, 1'b1);
      chk("t6_own_idx", idx_o, 3);
      tick();
      chk("t6_own_busy", busy_o, 1);
      flush_i = 1'b1;
      drive(4'b1000, 4'b0000, 1'b1);
      tick();
      flush_i = 1'b0;
      chk("t6_fl_busy", busy_o, 0);
      chk("t6_fl_ptr", dut.ptr_q, 0);
      chk("t6_fl_credit", dut.credit_q, 0);
      drive(4'b1001, 4'b1001, 1'b1);
      chk("t6_fl_idx", idx_o, 0);
      chk("t6_fl_gnt", gnt_o, 4'b0001);
      tick();
      weight_i = 16'h1133;
      drive(4'b0001, 4'b0001, 1'b1);
      tick();
      chk("t6_turn_busy", busy_o, 1);
      chk("t6_turn_credit", dut.credit_q, 2);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_busy", busy_o, 0);
      chk("t6_rst_ptr", dut.ptr_q, 0);
      chk("t6_rst_credit", dut.credit_q, 0);
      chk("t6_rst_owner", dut.owner_q, 0);
      req_i = '0;
      #20;
      rst_ni = 1'b1;
      #10;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
